// File: rtl/synapse_pkg.sv
// Shared status-word layout for CPU-visible FIFO registers.
// Bit positions plus a helper that packs the status word.
package synapse_pkg;

  localparam int EMPTY       = 0;
  localparam int FULL        = 1;
  localparam int OVERFLOW    = 2;
  localparam int UNDERFLOW   = 3;
  localparam int COUNT_LSB   = 8;
  localparam int COUNT_WIDTH = 8;

  function automatic logic [15:0] build_status(
    input logic                   is_empty,
    input logic                   is_full,
    input logic                   is_overflow,
    input logic                   is_underflow,
    input logic [COUNT_WIDTH-1:0] entries
  );
    logic [15:0] word;
    word                             = '0;
    word[EMPTY]                      = is_empty;
    word[FULL]                       = is_full;
    word[OVERFLOW]                   = is_overflow;
    word[UNDERFLOW]                  = is_underflow;
    word[COUNT_LSB +: COUNT_WIDTH]   = entries;
    return word;
  endfunction

endpackage

// File: rtl/read_fifo_reg_fifo_ptr.sv
// Read/write pointers and occupancy count for a power-of-two FIFO.
// Pointers wrap naturally at DEPTH_LOG2 bits; enables must already be qualified.
module fifo_ptr #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  sysclk,
  input  logic                  sysreset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DEPTH_LOG2-1:0] wr_ptr,
  output logic [DEPTH_LOG2-1:0] rd_ptr,
  output logic [DEPTH_LOG2:0]   count
);

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)
        count <= count + 1'b1;
      else if (rd_en && !wr_en)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/read_fifo_reg.sv
// CPU-readable FIFO register: hardware pushes words, CPU pops them via data_out,
// with sticky overflow/underflow flags and a packed status word.
module read_fifo_reg
  import synapse_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             sysclk,
  input  logic             sysreset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             read,
  input  logic             clear_flags,
  output logic [15:0]      data_out,
  output logic [15:0]      status_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  empty;
  logic                  full;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  overflow;
  logic                  underflow;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // A full FIFO still takes a push when a pop frees the head slot in the same cycle.
  assign push_ok = push && !sysreset && (!full || read);
  assign pop_ok  = read && !sysreset && !empty;

  fifo_ptr #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ptr (
    .sysclk  (sysclk),
    .sysreset(sysreset),
    .wr_en   (push_ok),
    .rd_en   (pop_ok),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .count   (count)
  );

  always_ff @(posedge sysclk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Setting events take priority over clear_flags so no event is lost.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full && !read)
        overflow <= 1'b1;
      else if (clear_flags)
        overflow <= 1'b0;
      if (read && empty)
        underflow <= 1'b1;
      else if (clear_flags)
        underflow <= 1'b0;
    end
  end

  always_comb begin
    data_out = '0;
    if (!empty) data_out[WIDTH-1:0] = mem[rd_ptr];
  end

  assign status_out = build_status(empty, full, overflow, underflow, COUNT_WIDTH'(count));

endmodule

// File: tb/tb_read_fifo_reg.sv
// Scoreboard bench: a 16-bit and a 4-bit instance share stimulus; a queue model
// supplies expected pop data and status after every cycle.
module tb_read_fifo_reg;

  logic        sysclk;
  logic        sysreset;
  logic        push;
  logic [15:0] push_data;
  logic        read;
  logic        clear_flags;
  logic [15:0] data_out;
  logic [15:0] status_out;
  logic [15:0] data_out4;
  logic [15:0] status_out4;

  logic [15:0] scoreboard [$];
  bit          model_ov;
  bit          model_un;
  int          checks;
  int          errors;

  read_fifo_reg #(.WIDTH(16), .DEPTH_LOG2(3)) dut (
    .sysclk     (sysclk),
    .sysreset   (sysreset),
    .push       (push),
    .push_data  (push_data),
    .read       (read),
    .clear_flags(clear_flags),
    .data_out   (data_out),
    .status_out (status_out)
  );

  read_fifo_reg #(.WIDTH(4), .DEPTH_LOG2(3)) dut4 (
    .sysclk     (sysclk),
    .sysreset   (sysreset),
    .push       (push),
    .push_data  (push_data[3:0]),
    .read       (read),
    .clear_flags(clear_flags),
    .data_out   (data_out4),
    .status_out (status_out4)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] expectedStatus();
    int n;
    n = scoreboard.size();
    return {8'(n), 4'b0000, model_un, model_ov, (n == 8), (n == 0)};
  endfunction

  task automatic checkState();
    logic [15:0] head;
    head = (scoreboard.size() > 0) ? scoreboard[0] : 16'h0000;
    checkOutput("data", data_out, head);
    checkOutput("status", status_out, expectedStatus());
    checkOutput("data4", data_out4, head & 16'h000F);
    checkOutput("status4", status_out4, expectedStatus());
  endtask

  // Called just after a falling edge; returns after the next falling edge.
  task automatic applyStimulus(input logic p, input logic [15:0] d, input logic r, input logic c);
    bit          was_empty;
    bit          was_full;
    logic [15:0] popped;
    push        = p;
    push_data   = d;
    read        = r;
    clear_flags = c;
    was_empty   = (scoreboard.size() == 0);
    was_full    = (scoreboard.size() == 8);
    if (r && !was_empty) begin
      popped = scoreboard.pop_front();
      checkOutput("pop_data", data_out, popped);
      checkOutput("pop_data4", data_out4, popped & 16'h000F);
    end
    if (p && (!was_full || r)) scoreboard.push_back(d);
    if (c) begin
      model_ov = 1'b0;
      model_un = 1'b0;
    end
    if (p && was_full && !r) model_ov = 1'b1;
    if (r && was_empty) model_un = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    push        = 1'b0;
    read        = 1'b0;
    clear_flags = 1'b0;
    checkState();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    model_ov    = 1'b0;
    model_un    = 1'b0;
    sysreset    = 1'b1;
    push        = 1'b0;
    push_data   = 16'h0000;
    read        = 1'b0;
    clear_flags = 1'b0;

    #2;
    checkOutput("reset_data", data_out, 16'h0000);
    checkOutput("reset_status", status_out, 16'h0001);
    @(negedge sysclk);
    sysreset = 1'b0;
    checkState();

    // Single push then pop
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
    checkOutput("push1_data", data_out, 16'h1234);
    checkOutput("push1_status", status_out, 16'h0100);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("pop1_status", status_out, 16'h0001);

    // Nine pushes into eight slots: last word dropped, overflow set
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
    checkOutput("full_status", status_out, 16'h0806);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("drained_status", status_out, 16'h0005);

    // Underflow and clear priority
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("clear_status", status_out, 16'h0001);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("underflow_status", status_out, 16'h0009);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("clear2_status", status_out, 16'h0001);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("clear_vs_under", status_out, 16'h0009);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);

    // Simultaneous push and read when full
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hAAAA, 1'b1, 1'b0);
    checkOutput("full_pushpop", status_out, 16'h0802);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("aaaa_head", data_out, 16'hAAAA);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    // Simultaneous push and read when empty
    applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0);
    checkOutput("empty_pushpop", status_out, 16'h0108);
    checkOutput("narrow_data", data_out4, 16'h000F);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);

    // Interleaved traffic forcing pointer wrap
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b1, 16'h1111 * 16'(i + 1), (i % 3) != 0, 1'b0);
    while (scoreboard.size() > 0) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    // Reset asserted mid-period with five entries held
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h0C00 + 16'(i), 1'b0, 1'b0);
    checkOutput("five_status", status_out, 16'h0500);
    #2;
    sysreset = 1'b1;
    #1;
    checkOutput("midreset_status", status_out, 16'h0001);
    checkOutput("midreset_data", data_out, 16'h0000);
    scoreboard.delete();
    model_ov = 1'b0;
    model_un = 1'b0;
    push      = 1'b1;
    push_data = 16'h5555;
    read      = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    checkState();
    push     = 1'b0;
    read     = 1'b0;
    sysreset = 1'b0;
    checkState();
    applyStimulus(1'b1, 16'h0042, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
